// File: rtl/panel_input_port_if.sv
// Operator panel input bus: raw switch/button inputs, CPU read strobe and
// held-byte status returned to the CPU.
interface panel_input_port_if;
  logic [7:0] io_dip;
  logic       io_button;
  logic       rd_ack;
  logic [7:0] in_data;
  logic       in_valid;
  logic       overrun;
  logic       btn_level;

  modport master (
    output io_dip, io_button, rd_ack,
    input  in_data, in_valid, overrun, btn_level
  );

  modport slave (
    input  io_dip, io_button, rd_ack,
    output in_data, in_valid, overrun, btn_level
  );
endinterface

// File: rtl/panel_input_port.sv
// Captures a debounced DIP byte on each debounced "enter" press and holds it
// for the CPU until a one-cycle rd_ack consumes it.
module panel_input_port #(
  parameter int TICK_DIV = 20000,
  parameter int DB_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  panel_input_port_if.slave   bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam int NSIG = 9;  // bit 8 = button, bits 7:0 = DIP bank

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [NSIG-1:0] sync1_q, sync2_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [CW-1:0]   db_cnt_q [NSIG];
  logic [CW-1:0]   db_cnt_d [NSIG];
  logic [NSIG-1:0] db_level_q, db_level_d;
  logic [0:0]      state_q, state_d;
  logic            press;
  logic [7:0]      in_data_q, in_data_d;
  logic            in_valid_q, in_valid_d;
  logic            overrun_q, overrun_d;
  logic            consume;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    if (tick) begin
      for (int i = 0; i < NSIG; i++) begin
        if (sync2_q[i] != db_level_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_level_d[i] = ~db_level_q[i];
            db_cnt_d[i]   = '0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + CW'(1);
          end
        end else begin
          db_cnt_d[i] = '0;
        end
      end
    end
  end

  // One press per debounced rising level; HELD blocks auto-repeat.
  always_comb begin
    state_d = state_q;
    press   = 1'b0;
    case (state_q)
      ST_IDLE: if (db_level_q[8]) begin
        state_d = ST_HELD;
        press   = 1'b1;
      end
      ST_HELD: if (!db_level_q[8]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A consume in the same cycle as a press frees the slot for the new byte.
  assign consume = bus.rd_ack && in_valid_q;

  always_comb begin
    in_data_d  = in_data_q;
    in_valid_d = in_valid_q;
    overrun_d  = overrun_q;
    if (bus.rd_ack) overrun_d = 1'b0;
    if (consume)    in_valid_d = 1'b0;
    if (press) begin
      if (!in_valid_q || consume) begin
        in_data_d  = db_level_q[7:0];
        in_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      db_level_q <= '0;
      state_q    <= ST_IDLE;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element to discard any partial debounce count.
      for (int i = 0; i < NSIG; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {bus.io_button, bus.io_dip};
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      db_level_q <= db_level_d;
      state_q    <= state_d;
      in_data_q  <= in_data_d;
      in_valid_q <= in_valid_d;
      overrun_q  <= overrun_d;
      for (int i = 0; i < NSIG; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign bus.in_data   = in_data_q;
  assign bus.in_valid  = in_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.btn_level = db_level_q[8];

endmodule
